// File: rtl/acf_axil_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI4-Lite master port.
// Only one transaction is outstanding at a time. The granted requester's
// we/addr/wdata are latched at grant, so later input changes do not affect
// the transaction in flight.
//
// Handshake rule on every AXI channel: a beat transfers on the rising edge
// where VALID and READY are both high. Once VALID is raised, it and its
// payload hold until that edge. All VALID/READY outputs come from registers.
module acf_axil_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    // requester side
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            ack,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            resp,
    // AW channel
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    // W channel
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    // B channel
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    // AR channel
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    // R channel
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    // debug: current FSM state
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic [1:0]          ack_q, ack_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          resp_q;
    logic                pick;
    logic                latch_en;
    logic                cap_b;
    logic                cap_r;

    // Next-state, grant and channel-control decode
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ack_d     = 2'b00;
        latch_en  = 1'b0;
        cap_b     = 1'b0;
        cap_r     = 1'b0;
        // On contention the requester not granted last wins.
        pick      = (req == 2'b11) ? ~last_q : req[1];
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d  = pick;
                    last_d   = pick;
                    latch_en = 1'b1;
                    if (we[pick]) begin
                        state_d   = WR_ADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                // AW and W retire independently; move on once both have gone.
                if (M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WREADY)  wvalid_d  = 1'b0;
                if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    cap_b    = 1'b1;
                    ack_d    = grant_q ? 2'b10 : 2'b01;
                    state_d  = DONE;
                end
            end
            RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    cap_r    = 1'b1;
                    ack_d    = grant_q ? 2'b10 : 2'b01;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // req is deliberately ignored here; arbitration resumes in IDLE.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, grant pointer and registered channel controls
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
        end
    end

    // Request latch at grant and response capture at completion
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
        end else begin
            if (latch_en) begin
                addr_q  <= pick ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
                wdata_q <= pick ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
            end
            if (cap_b) begin
                resp_q <= M_AXI_BRESP;
            end
            if (cap_r) begin
                rdata_q <= M_AXI_RDATA;
                resp_q  <= M_AXI_RRESP;
            end
        end
    end

    assign ack           = ack_q;
    assign rdata         = rdata_q;
    assign resp          = resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_acf_axil_arbiter.sv
// Bench for acf_axil_arbiter: a behavioural AXI4-Lite slave with a small
// register memory and programmable per-channel latencies, a round-robin
// grant-order model and a scoreboard of expected granted requesters.
module tb_acf_axil_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    // ---------------- clock / reset ----------------
    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    // ---------------- DUT signals ----------------
    logic [1:0]          req = 2'b00;
    logic [1:0]          we = 2'b00;
    logic [2*ADDR_W-1:0] addr = '0;
    logic [2*DATA_W-1:0] wdata = '0;
    logic [1:0]          ack;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          resp;
    logic [ADDR_W-1:0]   M_AXI_AWADDR;
    logic [2:0]          M_AXI_AWPROT;
    logic                M_AXI_AWVALID;
    logic                M_AXI_AWREADY = 1'b0;
    logic [DATA_W-1:0]   M_AXI_WDATA;
    logic [3:0]          M_AXI_WSTRB;
    logic                M_AXI_WVALID;
    logic                M_AXI_WREADY = 1'b0;
    logic [1:0]          M_AXI_BRESP = 2'b00;
    logic                M_AXI_BVALID = 1'b0;
    logic                M_AXI_BREADY;
    logic [ADDR_W-1:0]   M_AXI_ARADDR;
    logic [2:0]          M_AXI_ARPROT;
    logic                M_AXI_ARVALID;
    logic                M_AXI_ARREADY = 1'b0;
    logic [DATA_W-1:0]   M_AXI_RDATA = '0;
    logic [1:0]          M_AXI_RRESP = 2'b00;
    logic                M_AXI_RVALID = 1'b0;
    logic                M_AXI_RREADY;
    logic [2:0]          dbg_state_o;

    acf_axil_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .resp(resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];          // expected grant order (requester ids)
    logic        rr_last = 1'b1;   // model: requester granted last
    logic [31:0] prev_rdata = '0;  // model: value rdata must show
    logic [31:0] mem[4];           // slave register file
    bit          req_we[2];
    logic [3:0]  req_addr[2];
    logic [31:0] req_wdata[2];

    // slave controls and observations
    int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    int resp_mode = 0;             // <0: random response code
    bit r_hold = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic [1:0] slave_resp = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] pick_resp();
        int r;
        r = $urandom_range(0, 3);
        return (r < 2) ? 2'b00 : ((r == 2) ? 2'b10 : 2'b11);
    endfunction

    // ---------------- behavioural AXI4-Lite slave ----------------
    // Acts on falling edges: DUT valids are registered, so the decision made
    // here transfers on the following rising edge.
    initial begin : slave
        bit aw_got, w_got, ar_got, b_fire, r_fire, aw_prev, w_prev;
        int aw_wait, w_wait, b_wait, ar_wait, r_wait;
        logic [3:0]  aw_a, ar_a;
        logic [31:0] w_d;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0; aw_prev = 0; w_prev = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_a = '0; ar_a = '0; w_d = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0; aw_prev = 0; w_prev = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
                M_AXI_BVALID = 0; M_AXI_RVALID = 0;
                continue;
            end
            if (b_fire) begin M_AXI_BVALID = 0; b_fire = 0; end
            if (r_fire) begin M_AXI_RVALID = 0; r_fire = 0; end
            if (aw_prev) chk("aw_drop", M_AXI_AWVALID, 0);
            if (w_prev)  chk("w_drop", M_AXI_WVALID, 0);
            aw_prev = 0; w_prev = 0;
            // write response once both address and data have transferred
            if (aw_got && w_got) begin
                if (b_wait >= b_lat) begin
                    slave_resp = (resp_mode < 0) ? pick_resp() : resp_mode[1:0];
                    if (slave_resp == 2'b00) mem[aw_a[3:2]] = w_d;
                    M_AXI_BRESP = slave_resp; M_AXI_BVALID = 1;
                    aw_got = 0; w_got = 0; b_wait = 0; b_cnt++;
                end else b_wait++;
            end
            // read data once the address has transferred
            if (ar_got && !r_hold) begin
                if (r_wait >= r_lat) begin
                    slave_resp = (resp_mode < 0) ? pick_resp() : resp_mode[1:0];
                    M_AXI_RDATA = mem[ar_a[3:2]]; M_AXI_RRESP = slave_resp; M_AXI_RVALID = 1;
                    ar_got = 0; r_wait = 0; r_cnt++;
                end else r_wait++;
            end
            // AW
            if (M_AXI_AWVALID && aw_wait >= aw_lat) begin
                M_AXI_AWREADY = 1; aw_got = 1; aw_prev = 1; aw_a = M_AXI_AWADDR; aw_wait = 0; aw_cnt++;
                chk("aw_owner", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("awaddr", M_AXI_AWADDR, req_addr[exp_q[0][0]]);
                chk("awprot", M_AXI_AWPROT, 0);
            end else begin
                M_AXI_AWREADY = 0;
                aw_wait = M_AXI_AWVALID ? aw_wait + 1 : 0;
            end
            // W
            if (M_AXI_WVALID && w_wait >= w_lat) begin
                M_AXI_WREADY = 1; w_got = 1; w_prev = 1; w_d = M_AXI_WDATA; w_wait = 0; w_cnt++;
                if (exp_q.size() != 0) chk("wdata", M_AXI_WDATA, req_wdata[exp_q[0][0]]);
                chk("wstrb", M_AXI_WSTRB, 4'hF);
            end else begin
                M_AXI_WREADY = 0;
                w_wait = M_AXI_WVALID ? w_wait + 1 : 0;
            end
            // AR
            if (M_AXI_ARVALID && ar_wait >= ar_lat) begin
                M_AXI_ARREADY = 1; ar_got = 1; ar_a = M_AXI_ARADDR; ar_wait = 0; ar_cnt++;
                chk("ar_owner", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("araddr", M_AXI_ARADDR, req_addr[exp_q[0][0]]);
                chk("arprot", M_AXI_ARPROT, 0);
            end else begin
                M_AXI_ARREADY = 0;
                ar_wait = M_AXI_ARVALID ? ar_wait + 1 : 0;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) b_fire = 1;
            if (M_AXI_RVALID && M_AXI_RREADY) r_fire = 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int id, input bit w, input logic [3:0] a, input logic [31:0] d);
        req_we[id] = w; req_addr[id] = a; req_wdata[id] = d;
    endtask

    task automatic set_lat(input int a, input int w, input int b, input int ar, input int r);
        aw_lat = a; w_lat = w; b_lat = b; ar_lat = ar; r_lat = r;
    endtask

    task automatic clear_counts();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    endtask

    // Raise the requests in r, then retire every expected ack in model order.
    task automatic run_round(input logic [1:0] r, input bit scramble, output int lat);
        bit order[$];
        if (r == 2'b11) begin
            order.push_back(~rr_last); order.push_back(rr_last);
        end else begin
            order.push_back(r[1]);
        end
        @(negedge ACLK);
        foreach (order[k]) exp_q.push_back({1'b0, order[k]});
        for (int i = 0; i < 2; i++) begin
            we[i] = req_we[i];
            addr[i*ADDR_W +: ADDR_W] = req_addr[i];
            wdata[i*DATA_W +: DATA_W] = req_wdata[i];
        end
        clear_counts();
        req = r;
        lat = 0;
        foreach (order[k]) begin
            int waited;
            int id;
            id = order[k];
            waited = 0;
            do begin
                @(negedge ACLK);
                waited++;
                if (scramble && (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID)) begin
                    addr[id*ADDR_W +: ADDR_W] = 4'($urandom);
                    wdata[id*DATA_W +: DATA_W] = $urandom;
                end
            end while (ack == 2'b00 && waited < 200);
            if (k == 0) lat = waited;
            chk("ack_timeout", waited < 200, 1);
            chk("ack", ack, (id == 1) ? 2'b10 : 2'b01);
            chk("resp", resp, slave_resp);
            if (!req_we[id]) prev_rdata = mem[req_addr[id][3:2]];
            chk("rdata", rdata, prev_rdata);
            chk("aw_cnt", aw_cnt, req_we[id] ? 1 : 0);
            chk("w_cnt", w_cnt, req_we[id] ? 1 : 0);
            chk("b_cnt", b_cnt, req_we[id] ? 1 : 0);
            chk("ar_cnt", ar_cnt, req_we[id] ? 0 : 1);
            clear_counts();
            void'(exp_q.pop_front());
            rr_last = id[0];
            req[id] = 1'b0;
            @(negedge ACLK);
            chk("ack_pulse", ack, 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int lat;
        logic [1:0] r;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        mem[2] = 32'h3;
        set_lat(0, 0, 0, 0, 0);
        ARESETN = 0;
        repeat (3) @(posedge ACLK);
        #2 ARESETN = 1;
        @(negedge ACLK);
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_resp", resp, 0);
        chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        chk("rst_state", dbg_state_o, 0);

        // single write, slave always ready
        resp_mode = 0;
        set_req(0, 1, 4'h4, 32'h0000_0002);
        run_round(2'b01, 0, lat);
        chk("wr_latency", lat, 3);

        // single read of a preloaded register
        set_req(1, 0, 4'h8, 32'h0);
        run_round(2'b10, 0, lat);
        chk("rd_latency", lat, 3);
        chk("rd_value", rdata, 32'h3);

        // contention: both write, grants alternate
        set_req(0, 1, 4'h0, 32'hA0A0_0000);
        set_req(1, 1, 4'hC, 32'hB1B1_0000);
        run_round(2'b11, 0, lat);
        req_wdata[0] = 32'hA0A0_0001; req_wdata[1] = 32'hB1B1_0001;
        run_round(2'b11, 0, lat);

        // split handshake, with requester inputs scrambled after grant
        set_lat(0, 4, 0, 0, 0);
        set_req(0, 1, 4'h8, 32'h5555_AAAA);
        run_round(2'b01, 1, lat);

        // error response: rdata must keep the preceding read value
        set_lat(0, 0, 0, 0, 0);
        set_req(1, 0, 4'h8, 32'h0);
        run_round(2'b10, 0, lat);
        resp_mode = 2;
        set_req(0, 1, 4'h4, 32'hDEAD_BEEF);
        run_round(2'b01, 0, lat);
        chk("err_resp", resp, 2'b10);
        resp_mode = 0;
        set_req(1, 0, 4'h4, 32'h0);
        run_round(2'b10, 0, lat);
        chk("err_nowrite", rdata, 32'h2);

        // randomized traffic
        resp_mode = -1;
        for (int n = 0; n < 40; n++) begin
            set_lat($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            for (int i = 0; i < 2; i++)
                set_req(i, $urandom_range(0, 1), 4'($urandom), $urandom);
            r = 2'($urandom_range(1, 3));
            run_round(r, (r != 2'b11) && ($urandom_range(0, 1) == 1), lat);
        end

        // reset in RD_DATA with read data withheld
        resp_mode = 0;
        set_lat(0, 0, 0, 0, 0);
        set_req(0, 0, 4'h8, 32'h0);
        @(negedge ACLK);
        exp_q.push_back(2'd0);
        r_hold = 1;
        we[0] = 1'b0; addr[ADDR_W-1:0] = 4'h8;
        req = 2'b01;
        for (int i = 0; i < 50 && !M_AXI_RREADY; i++) begin
            @(negedge ACLK);
            chk("abort_noack", ack, 0);
        end
        chk("abort_rready_seen", M_AXI_RREADY, 1);
        @(posedge ACLK);
        #2 ARESETN = 0; req = 2'b00;
        @(posedge ACLK);
        #2 ARESETN = 1;
        exp_q.delete();
        r_hold = 0;
        rr_last = 1'b1;
        prev_rdata = 32'h0;
        clear_counts();
        @(negedge ACLK);
        chk("abort_rready", M_AXI_RREADY, 0);
        chk("abort_ack", ack, 0);
        chk("abort_state", dbg_state_o, 0);
        chk("abort_rdata", rdata, 0);
        repeat (3) begin
            @(negedge ACLK);
            chk("abort_quiet", {ack, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        end
        // pointer restarts at 1: requester 0 wins the first contention
        set_req(0, 1, 4'h0, 32'h1234_5678);
        set_req(1, 1, 4'h4, 32'h8765_4321);
        run_round(2'b11, 0, lat);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
